// File: rtl/mux4_arb_pkg.sv
// Shared types, constants and index helpers for the 4-requester round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef logic [NUM_REQ-1:0] vec_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Binary index of a one-hot vector; all-zero maps to index 0.
    function automatic idx_t onehot_to_idx(input vec_t oh);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx_t'(i);
            end
        end
        return idx;
    endfunction

    // One-hot vector with only bit idx set.
    function automatic vec_t idx_to_onehot(input idx_t idx);
        return vec_t'(1) << idx;
    endfunction

    // Index `off` positions after `base`, wrapping modulo NUM_REQ.
    function automatic idx_t idx_add(input idx_t base, input int off);
        return idx_t'(base + off[IDX_W-1:0]);
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters and the arbiter.
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    vec_t req;
    vec_t grant;
    logic select0;
    logic select1;
    logic busy;

    // Requester side: drives requests, observes grant and mux selects.
    modport master (
        output req,
        input  grant,
        input  select0,
        input  select1,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req,
        output grant,
        output select0,
        output select1,
        output busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: scans upward from ptr+1 with wrap and returns
// the first active request, optionally ignoring one excluded index.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  vec_t req,
    input  idx_t ptr,
    input  logic excl_en,
    input  idx_t excl_idx,
    output logic found,
    output idx_t win_idx
);

    // First eligible requester after ptr in round-robin order.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found   = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[idx_add(ptr, k)] &&
                !(excl_en && (idx_add(ptr, k) == excl_idx))) begin
                found   = 1'b1;
                win_idx = idx_add(ptr, k);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the selects of a shared 4:1 mux, with a
// per-tenure burst limit. All outputs come from flops; req only feeds next state.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux4_rr_arbiter_if.slave   bus
);

    localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    idx_t             ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    vec_t             grant_q, grant_d;
    idx_t             sel_q,   sel_d;

    idx_t holder;
    logic holder_req;
    logic expiry;
    logic pick_found;
    idx_t pick_idx;

    // The holder is whoever owns the registered grant; ptr_q tracks the same index.
    assign holder     = onehot_to_idx(grant_q);
    assign holder_req = bus.req[holder];
    assign expiry     = (state_q == GRANT) && holder_req && (cnt_q == CNT_MAX);

    // One picker serves idle arbitration, release and burst expiry; only
    // expiry excludes the current holder.
    rr_pick4 u_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .excl_en  (expiry),
        .excl_idx (holder),
        .found    (pick_found),
        .win_idx  (pick_idx)
    );

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    grant_d = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                end else begin
                    grant_d = '0;
                end
            end

            GRANT: begin
                if (!holder_req || expiry) begin
                    if (pick_found) begin
                        // Direct hand-off, no idle gap.
                        ptr_d   = pick_idx;
                        cnt_d   = '0;
                        grant_d = idx_to_onehot(pick_idx);
                        sel_d   = pick_idx;
                    end else if (!holder_req) begin
                        // Nobody left: drop grant, keep selects so the mux output is stable.
                        state_d = IDLE;
                        cnt_d   = '0;
                        grant_d = '0;
                    end else begin
                        // Burst expired with no competitor: holder starts a fresh burst.
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer, burst counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= idx_t'(NUM_REQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.select0 = sel_q[0];
    assign bus.select1 = sel_q[1];
    assign bus.busy    = |grant_q;

endmodule
